// File: rtl/vga_pixel_pipeline_if.sv
// Pixel stream bundle: upstream timing/counter signals in, DAC-side colour and syncs out.
// master drives the timing stream; slave is the pixel pipeline.
interface vga_pixel_pipeline_if #(
    parameter int unsigned COLOR_W = 4
);
    logic [11:0]        h_count;
    logic [11:0]        v_count;
    logic               h_sync;
    logic               v_sync;
    logic               pixel_enable;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_de;

    modport master (
        output h_count, v_count, h_sync, v_sync, pixel_enable,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
    );

    modport slave (
        input  h_count, v_count, h_sync, v_sync, pixel_enable,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
    );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// Two-stage test-pattern generator behind the VGA timing generator: S1 registers the
// timing stream and tracks bars/frames, S2 computes the colour and registers all outputs.
module vga_pixel_pipeline #(
    parameter int unsigned COLOR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vga_pixel_pipeline_if.slave    vga,
    input  logic [11:0]            width,
    input  logic [1:0]             mode_sel,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   frame_start,
    output logic [7:0]             frame_count
);

    typedef enum logic [1:0] {
        ModeBars     = 2'd0,
        ModeChecker  = 2'd1,
        ModeGradient = 2'd2,
        ModeSolid    = 2'd3
    } mode_e;

    // Stage 1 state
    logic [11:0] h_q, v_q;
    logic        hs_q, vs_q, de_q;
    logic        prev_zero_q;
    logic        fs_q;
    mode_e       mode_q;
    logic [7:0]  fcnt_q;
    logic [8:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;

    logic        in_zero;
    logic        fs_evt;
    logic [8:0]  bw;

    assign in_zero = (vga.h_count == 12'd0) && (vga.v_count == 12'd0);
    // Held (0,0) only counts on its first sample.
    assign fs_evt  = in_zero && !prev_zero_q;
    assign bw      = (width[11:3] == 9'd0) ? 9'd1 : width[11:3];

    always_comb begin
        bar_cnt_d = bar_cnt_q + 9'd1;
        bar_idx_d = bar_idx_q;
        if (vga.h_count == 12'd0) begin
            bar_cnt_d = 9'd0;
            bar_idx_d = 3'd0;
        end else if (bar_cnt_q == bw - 9'd1) begin
            bar_cnt_d = 9'd0;
            if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q         <= 12'd0;
            v_q         <= 12'd0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            prev_zero_q <= 1'b0;
            fs_q        <= 1'b0;
            mode_q      <= ModeBars;
            fcnt_q      <= 8'd0;
            bar_cnt_q   <= 9'd0;
            bar_idx_q   <= 3'd0;
        end else begin
            h_q         <= vga.h_count;
            v_q         <= vga.v_count;
            hs_q        <= vga.h_sync;
            vs_q        <= vga.v_sync;
            de_q        <= vga.pixel_enable;
            prev_zero_q <= in_zero;
            fs_q        <= fs_evt;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            if (fs_evt) begin
                mode_q <= mode_e'(mode_sel);
                fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    // Stage 2 colour
    logic [COLOR_W-1:0] r_d, g_d, b_d;
    logic [7:0]         fc_field;

    // Frame-counter nibble left-justified so gradient B takes its top COLOR_W bits.
    assign fc_field = {fcnt_q[3:0], 4'b0000};

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        unique case (mode_q)
            ModeBars: begin
                r_d = {COLOR_W{~bar_idx_q[1]}};
                g_d = {COLOR_W{~bar_idx_q[2]}};
                b_d = {COLOR_W{~bar_idx_q[0]}};
            end
            ModeChecker: begin
                r_d = {COLOR_W{h_q[5] ^ v_q[5]}};
                g_d = {COLOR_W{h_q[5] ^ v_q[5]}};
                b_d = {COLOR_W{h_q[5] ^ v_q[5]}};
            end
            ModeGradient: begin
                r_d = h_q[7 -: COLOR_W];
                g_d = v_q[7 -: COLOR_W];
                b_d = fc_field[7 -: COLOR_W];
            end
            ModeSolid: begin
                r_d = solid_rgb[3*COLOR_W-1 -: COLOR_W];
                g_d = solid_rgb[2*COLOR_W-1 -: COLOR_W];
                b_d = solid_rgb[COLOR_W-1 -: COLOR_W];
            end
            default: begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
        endcase
        if (!de_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga.vga_r   <= '0;
            vga.vga_g   <= '0;
            vga.vga_b   <= '0;
            vga.vga_hs  <= 1'b1;
            vga.vga_vs  <= 1'b1;
            vga.vga_de  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            vga.vga_r   <= r_d;
            vga.vga_g   <= g_d;
            vga.vga_b   <= b_d;
            vga.vga_hs  <= hs_q;
            vga.vga_vs  <= vs_q;
            vga.vga_de  <= de_q;
            frame_start <= fs_q;
            frame_count <= fcnt_q;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Bench for vga_pixel_pipeline: directed frames from a bench-side timing generator, a
// per-pixel pattern model delayed two cycles, and literal pixel/counter expectations.
module tb_vga_pixel_pipeline;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] width;
    logic [1:0]  mode_sel;
    logic [11:0] solid_rgb;
    logic        frame_start;
    logic [7:0]  frame_count;

    vga_pixel_pipeline_if #(.COLOR_W(4)) vif ();

    vga_pixel_pipeline #(.COLOR_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vga         (vif),
        .width       (width),
        .mode_sel    (mode_sel),
        .solid_rgb   (solid_rgb),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hs, vs, de, fs;
        logic [7:0]  fc;
        logic        chk_rgb;
        int          h, v;
    } exp_t;

    localparam exp_t RstExp = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0,
                                fc: 8'd0, chk_rgb: 1'b1, h: -1, v: -1};

    int total = 0;
    int bad   = 0;
    int fs_cnt = 0;
    int fs_snap = 0;
    int hs_run = 0, hs_last = 0, de_run = 0, de_last = 0;
    bit chk_on = 0;

    // Bench-side model state
    exp_t        pend = RstExp;
    exp_t        out_exp = RstExp;
    bit          m_prev_zero = 0;
    logic [7:0]  m_fc = 8'd0;
    int          m_mode = 0;
    bit          m_bar_ok = 0;
    logic [11:0] bar_tab [8];

    // Watch points: literal colour expected at a given output pixel
    int          watch_n = 0;
    int          watch_h [8];
    int          watch_v [8];
    logic [11:0] watch_val [8];
    bit          watch_hit [8];

    // Generator hooks
    int sw_h = -1, sw_v = -1;
    logic [1:0] sw_mode = 2'd0;
    int rst_h = -1, rst_v = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Model: expected output for each sampled input, emitted two edges later
    initial begin
        bar_tab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_prev_zero = 0;
                m_fc        = 8'd0;
                m_mode      = 0;
                m_bar_ok    = 0;
                pend        = RstExp;
                out_exp     = RstExp;
            end else begin
                automatic exp_t e;
                automatic int hh = int'(vif.h_count);
                automatic int vv = int'(vif.v_count);
                automatic int bw = int'(width) / 8;
                automatic int idx;
                automatic bit zero = (hh == 0) && (vv == 0);
                out_exp = pend;
                e.fs = zero && !m_prev_zero;
                m_prev_zero = zero;
                if (e.fs) begin
                    m_mode = int'(mode_sel);
                    m_fc   = m_fc + 8'd1;
                end
                if (hh == 0) m_bar_ok = 1;
                if (bw == 0) bw = 1;
                idx = hh / bw;
                if (idx > 7) idx = 7;
                e.chk_rgb = 1'b1;
                case (m_mode)
                    0: begin
                        e.rgb = bar_tab[idx];
                        e.chk_rgb = m_bar_ok;
                    end
                    1: e.rgb = (((hh / 32) % 2) != ((vv / 32) % 2)) ? 12'hFFF : 12'h000;
                    2: e.rgb = {4'((hh % 256) / 16), 4'((vv % 256) / 16), m_fc[3:0]};
                    default: e.rgb = solid_rgb;
                endcase
                if (!vif.pixel_enable) begin
                    e.rgb = 12'h000;
                    e.chk_rgb = 1'b1;
                end
                e.hs = vif.h_sync;
                e.vs = vif.v_sync;
                e.de = vif.pixel_enable;
                e.fc = m_fc;
                e.h  = hh;
                e.v  = vv;
                pend = e;
            end
        end
    end

    // Compare process: every cycle, outputs against the model and watch points
    initial begin
        forever begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_cnt++;
            if (vif.vga_hs === 1'b0) hs_run++;
            else if (hs_run != 0) begin hs_last = hs_run; hs_run = 0; end
            if (vif.vga_de === 1'b1) de_run++;
            else if (de_run != 0) begin de_last = de_run; de_run = 0; end
            if (chk_on) begin
                automatic exp_t e = out_exp;
                automatic logic [23:0] a = {vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hs,
                                            vif.vga_vs, vif.vga_de, frame_start, frame_count};
                automatic logic [23:0] x = {e.rgb, e.hs, e.vs, e.de, e.fs, e.fc};
                if (!e.chk_rgb) begin
                    a[23:12] = 12'h000;
                    x[23:12] = 12'h000;
                end
                chk("pipe_out", 32'(a), 32'(x));
                for (int i = 0; i < watch_n; i++) begin
                    if (e.h == watch_h[i] && e.v == watch_v[i]) begin
                        watch_hit[i] = 1;
                        chk($sformatf("pixel(%0d,%0d)", watch_h[i], watch_v[i]),
                            32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(watch_val[i]));
                    end
                end
            end
        end
    end

    task automatic add_watch(input int hh, input int vv, input logic [11:0] val);
        watch_h[watch_n]   = hh;
        watch_v[watch_n]   = vv;
        watch_val[watch_n] = val;
        watch_hit[watch_n] = 0;
        watch_n++;
    endtask

    task automatic end_watches();
        for (int i = 0; i < watch_n; i++) begin
            chk($sformatf("watch_reached(%0d,%0d)", watch_h[i], watch_v[i]),
                32'(watch_hit[i]), 32'd1);
        end
        watch_n = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vif.h_count      = 12'hFFF;
            vif.v_count      = 12'hFFF;
            vif.pixel_enable = 1'b0;
            vif.h_sync       = 1'b1;
            vif.v_sync       = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'h0);
        chk({tag, "_syncs_de"}, 32'({vif.vga_hs, vif.vga_vs, vif.vga_de}), 32'b110);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    task automatic run_frame(input int w, input int ht, input int hss, input int hsl,
                             input int vt, input int va, input int vss, input int vsl,
                             input int hold0);
        width = 12'(w);
        for (int vv = 0; vv < vt; vv++) begin
            for (int hh = 0; hh < ht; hh++) begin
                automatic int reps = (hh == 0 && vv == 0) ? hold0 : 1;
                for (int r = 0; r < reps; r++) begin
                    @(negedge clk);
                    vif.h_count      = 12'(hh);
                    vif.v_count      = 12'(vv);
                    vif.pixel_enable = (hh < w) && (vv < va);
                    vif.h_sync       = !((hh >= hss) && (hh < hss + hsl));
                    vif.v_sync       = !((vv >= vss) && (vv < vss + vsl));
                    if (hh == sw_h && vv == sw_v) mode_sel = sw_mode;
                    if (hh == rst_h && vv == rst_v) begin
                        #2 reset_n = 1'b0;
                        #1 check_reset_outputs("midline_reset");
                        fs_snap = fs_cnt;
                    end
                    if (hh == rst_h + 3 && vv == rst_v) reset_n = 1'b1;
                end
            end
        end
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle(2);
        check_reset_outputs("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        width = 12'd640;
        mode_sel = 2'd0;
        solid_rgb = 12'h000;
        vif.h_count = 12'hFFF;
        vif.v_count = 12'hFFF;
        vif.pixel_enable = 1'b0;
        vif.h_sync = 1'b1;
        vif.v_sync = 1'b1;
        idle(3);
        check_reset_outputs("por");
        chk_on = 1;
        reset_n = 1'b1;
        idle(2);

        // Colour bars at 640 wide, 800-cycle lines with a 96-cycle hsync
        add_watch(0, 0, 12'hFFF);
        add_watch(79, 0, 12'hFFF);
        add_watch(80, 0, 12'hFF0);
        add_watch(159, 0, 12'hFF0);
        add_watch(560, 0, 12'h000);
        add_watch(639, 0, 12'h000);
        run_frame(640, 800, 656, 96, 3, 2, 2, 1, 1);
        end_watches();
        chk("hs_low_len", 32'(hs_last), 32'd96);
        chk("de_high_len", 32'(de_last), 32'd640);
        chk("fc_after_bars", 32'(frame_count), 32'd1);

        // Checkerboard
        mode_sel = 2'd1;
        add_watch(32, 0, 12'hFFF);
        add_watch(0, 0, 12'h000);
        add_watch(32, 32, 12'h000);
        add_watch(0, 32, 12'hFFF);
        run_frame(64, 80, 68, 8, 35, 34, 34, 1, 1);
        end_watches();
        chk("fc_after_checker", 32'(frame_count), 32'd2);

        // Mode request mid-frame stays pending until the next frame start
        mode_sel = 2'd0;
        sw_h = 100; sw_v = 200; sw_mode = 2'd2;
        add_watch(50, 201, 12'h0F0);
        run_frame(112, 120, 114, 4, 204, 202, 203, 1, 1);
        end_watches();
        sw_h = -1; sw_v = -1;
        add_watch(48, 80, 12'h354);
        run_frame(112, 120, 114, 4, 84, 82, 83, 1, 1);
        end_watches();
        chk("fc_after_gradient", 32'(frame_count), 32'd4);

        // (0,0) held for 10 cycles counts as one frame
        fs_snap = fs_cnt;
        run_frame(16, 20, 17, 2, 2, 1, 1, 1, 10);
        chk("held_origin_fs", 32'(fs_cnt - fs_snap), 32'd1);
        chk("held_origin_fc", 32'(frame_count), 32'd5);

        // 257 frames of solid colour: counter wraps back to 1
        do_reset();
        mode_sel = 2'd3;
        solid_rgb = 12'h5A3;
        fs_snap = fs_cnt;
        add_watch(3, 0, 12'h5A3);
        add_watch(18, 0, 12'h000);
        for (int f = 0; f < 257; f++) run_frame(16, 20, 17, 2, 2, 1, 1, 1, 1);
        end_watches();
        chk("wrap_fs_pulses", 32'(fs_cnt - fs_snap), 32'd257);
        chk("wrap_fc", 32'(frame_count), 32'd1);

        // Reset mid-line 300, then no frame start until the next input origin
        do_reset();
        mode_sel = 2'd1;
        rst_h = 8; rst_v = 300;
        run_frame(16, 20, 17, 2, 310, 305, 307, 1, 1);
        rst_h = -1; rst_v = -1;
        chk("no_fs_after_midreset", 32'(fs_cnt - fs_snap), 32'd0);
        chk("fc_after_midreset", 32'(frame_count), 32'd0);
        run_frame(16, 20, 17, 2, 2, 1, 1, 1, 1);
        chk("fs_next_frame", 32'(fs_cnt - fs_snap), 32'd1);
        chk("fc_next_frame", 32'(frame_count), 32'd1);

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
